shift_sub_divider: RTL

SHIFT_SUB_DIVIDER -- requirements
Module: shift_sub_divider

---
 rtl/shift_sub_divider.sv | 97 +++++++++
 1 files changed

// File: rtl/shift_sub_divider.sv
// Purpose: 16/8 unsigned restoring divider. Each RUN cycle retires one dividend bit, MSB first.
// Latency: 17 cycles from accept to done for a nonzero divisor; 1 cycle for divide-by-zero.
// Backpressure: start is taken only in IDLE or DONE, ignored during RUN; results hold until the next result.
module shift_sub_divider (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] dividend,
    input  logic [7:0]  divisor,
    output logic [15:0] quot,
    output logic [7:0]  rem,
    output logic        busy,
    output logic        done,
    output logic        div_zero
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]  state;
    logic [15:0] dvd_sr;
    logic [15:0] q_sr;
    logic [7:0]  dsr;
    logic [7:0]  pr;
    logic [4:0]  cnt;

    logic        accept;
    logic [8:0]  shifted;
    logic [8:0]  diff;
    logic        fits;
    logic [7:0]  pr_next;
    logic [15:0] q_next;

    assign accept = start && ((state == IDLE) || (state == DONE));

    // pr < dsr always holds, so shifted < 2*dsr and the 9-bit difference lies in
    // [-255, 254]; its sign bit is therefore an exact "shifted < divisor" borrow.
    assign shifted = {pr, dvd_sr[15]};
    assign diff    = shifted - {1'b0, dsr};
    assign fits    = ~diff[8];
    assign pr_next = fits ? diff[7:0] : shifted[7:0];
    assign q_next  = {q_sr[14:0], fits};

    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            dvd_sr   <= '0;
            q_sr     <= '0;
            dsr      <= '0;
            pr       <= '0;
            cnt      <= '0;
            quot     <= '0;
            rem      <= '0;
            div_zero <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        dvd_sr <= dividend;
                        dsr    <= divisor;
                        pr     <= '0;
                        q_sr   <= '0;
                        cnt    <= 5'd16;
                        if (divisor == 8'd0) begin
                            quot     <= 16'hFFFF;
                            rem      <= dividend[7:0];
                            div_zero <= 1'b1;
                            state    <= DONE;
                        end else begin
                            state <= RUN;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    dvd_sr <= {dvd_sr[14:0], 1'b0};
                    pr     <= pr_next;
                    q_sr   <= q_next;
                    cnt    <= cnt - 5'd1;
                    if (cnt == 5'd1) begin
                        quot     <= q_next;
                        rem      <= pr_next;
                        div_zero <= 1'b0;
                        state    <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
